// File: rtl/spi_slave_axis_if.sv
// Byte-wide AXI-Stream bundle shared by the SPI responder's receive and transmit sides.
// The master modport drives data toward the consumer; the slave modport accepts it.
interface spi_slave_axis_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;
   logic       tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/spi_slave_axis.sv
// SPI mode-0 responder oversampled in clk_core: MOSI bytes to m_axis (tlast on frame end), s_axis bytes to MISO.
// Latency: pin edge to strobe SYNC_STAGES+1 cycles; backpressure drops bytes into stat_overflow_cnt. Macro: SPI_SLAVE_STATS_EN.
module spi_slave_axis #(
   parameter bit         MSB_FIRST   = 1'b0,
   parameter logic [7:0] IDLE_BYTE   = 8'hFF,
   parameter int         SYNC_STAGES = 2
) (
   input  logic                    clk_core,
   input  logic                    clk_core_resn,
   input  logic                    spi_clk,
   input  logic                    spi_csn,
   input  logic                    spi_mosi,
   output logic                    spi_miso,
   output logic                    spi_miso_oe,
   spi_slave_axis_if.master        m_axis,
   spi_slave_axis_if.slave         s_axis,
   output logic                    busy,
   output logic [15:0]             stat_overflow_cnt,
   output logic [15:0]             stat_underrun_cnt
);
   localparam int S = SYNC_STAGES;

   typedef enum logic {IDLE, SHIFT} state_t;
   state_t state_q, state_d;

   logic [S:0]   sclk_sync_q, csn_sync_q;
   logic [S-1:0] mosi_sync_q;
   logic         sclk_rise, sclk_fall, csn_fall, csn_rise, mosi_s;

   logic [7:0] rx_shift_q, rx_shift_d, pend_q, pend_d, out_dat_q, out_dat_d;
   logic [7:0] hold_q, hold_d, tx_shift_q, tx_shift_d, push_dat;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       pend_vld_q, pend_vld_d, out_vld_q, out_vld_d, out_last_q, out_last_d;
   logic       hold_vld_q, hold_vld_d, tx_idle_q, tx_idle_d, tx_first_q, tx_first_d;
   logic       slot_end_q, slot_end_d, miso_q, miso_d;
   logic       push_vld, push_last, slot_start, ovf_inc, und_inc;
   logic       unused_tlast;

   assign unused_tlast = s_axis.tlast;

   // Synchronisers clear to 0 so a reset released mid-frame never fakes a CSn fall.
   always_ff @(posedge clk_core or negedge clk_core_resn) begin
      if (!clk_core_resn) begin
         sclk_sync_q <= '0;
         csn_sync_q  <= '0;
         mosi_sync_q <= '0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[S-1:0], spi_clk};
         csn_sync_q  <= {csn_sync_q[S-1:0], spi_csn};
         mosi_sync_q <= {mosi_sync_q[S-2:0], spi_mosi};
      end
   end

   assign sclk_rise = sclk_sync_q[S-1] & ~sclk_sync_q[S];
   assign sclk_fall = ~sclk_sync_q[S-1] & sclk_sync_q[S];
   assign csn_fall  = ~csn_sync_q[S-1] & csn_sync_q[S];
   assign csn_rise  = csn_sync_q[S-1] & ~csn_sync_q[S];
   assign mosi_s    = mosi_sync_q[S-1];

   always_comb begin
      state_d    = state_q;
      rx_shift_d = rx_shift_q;
      bit_cnt_d  = bit_cnt_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      out_dat_d  = out_dat_q;
      out_vld_d  = out_vld_q;
      out_last_d = out_last_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      tx_shift_d = tx_shift_q;
      tx_idle_d  = tx_idle_q;
      tx_first_d = tx_first_q;
      slot_end_d = slot_end_q;
      push_vld   = 1'b0;
      push_last  = 1'b0;
      push_dat   = pend_q;
      slot_start = 1'b0;
      ovf_inc    = 1'b0;
      und_inc    = 1'b0;

      case (state_q)
         IDLE: begin
            if (csn_fall) begin
               state_d    = SHIFT;
               slot_start = 1'b1;
            end
         end
         SHIFT: begin
            if (csn_rise) begin
               state_d    = IDLE;
               bit_cnt_d  = '0;
               rx_shift_d = '0;
               slot_end_d = 1'b0;
               tx_first_d = 1'b0;
               pend_vld_d = 1'b0;
               push_vld   = pend_vld_q;
               push_last  = 1'b1;
            end else if (sclk_rise) begin
               rx_shift_d = MSB_FIRST ? {rx_shift_q[6:0], mosi_s} : {mosi_s, rx_shift_q[7:1]};
               bit_cnt_d  = bit_cnt_q + 3'd1;
               if (tx_first_q) begin
                  tx_first_d = 1'b0;
                  und_inc    = tx_idle_q;
               end
               if (bit_cnt_q == 3'd7) begin
                  slot_end_d = 1'b1;
                  pend_d     = rx_shift_d;
                  pend_vld_d = 1'b1;
                  push_vld   = pend_vld_q;
               end
            end else if (sclk_fall) begin
               if (slot_end_q) begin
                  slot_start = 1'b1;
                  slot_end_d = 1'b0;
               end else begin
                  tx_shift_d = MSB_FIRST ? {tx_shift_q[6:0], 1'b0} : {1'b0, tx_shift_q[7:1]};
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (slot_start) begin
         tx_first_d = 1'b1;
         if (hold_vld_q) begin
            tx_shift_d = hold_q;
            hold_vld_d = 1'b0;
            tx_idle_d  = 1'b0;
         end else begin
            tx_shift_d = IDLE_BYTE;
            tx_idle_d  = 1'b1;
         end
      end

      if (!hold_vld_q && s_axis.tvalid) begin
         hold_d     = s_axis.tdata;
         hold_vld_d = 1'b1;
      end

      // The output register takes a push only if empty or draining this very cycle.
      if (push_vld) begin
         if (!out_vld_q || m_axis.tready) begin
            out_dat_d  = push_dat;
            out_last_d = push_last;
            out_vld_d  = 1'b1;
         end else begin
            ovf_inc = 1'b1;
         end
      end else if (out_vld_q && m_axis.tready) begin
         out_vld_d = 1'b0;
      end

      miso_d = (state_d == SHIFT) && (MSB_FIRST ? tx_shift_d[7] : tx_shift_d[0]);
   end

   always_ff @(posedge clk_core or negedge clk_core_resn) begin
      if (!clk_core_resn) begin
         state_q    <= IDLE;
         rx_shift_q <= '0;
         bit_cnt_q  <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         out_dat_q  <= '0;
         out_vld_q  <= 1'b0;
         out_last_q <= 1'b0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         tx_shift_q <= '0;
         tx_idle_q  <= 1'b0;
         tx_first_q <= 1'b0;
         slot_end_q <= 1'b0;
         miso_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rx_shift_q <= rx_shift_d;
         bit_cnt_q  <= bit_cnt_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         out_dat_q  <= out_dat_d;
         out_vld_q  <= out_vld_d;
         out_last_q <= out_last_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         tx_shift_q <= tx_shift_d;
         tx_idle_q  <= tx_idle_d;
         tx_first_q <= tx_first_d;
         slot_end_q <= slot_end_d;
         miso_q     <= miso_d;
      end
   end

   assign spi_miso      = miso_q;
   assign spi_miso_oe   = (state_q == SHIFT);
   assign busy          = (state_q == SHIFT);
   assign m_axis.tdata  = out_dat_q;
   assign m_axis.tvalid = out_vld_q;
   assign m_axis.tlast  = out_last_q;
   assign s_axis.tready = ~hold_vld_q;

`ifdef SPI_SLAVE_STATS_EN
   logic [15:0] ovf_cnt_q, und_cnt_q;

   always_ff @(posedge clk_core or negedge clk_core_resn) begin
      if (!clk_core_resn) begin
         ovf_cnt_q <= '0;
         und_cnt_q <= '0;
      end else begin
         if (ovf_inc && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_q <= ovf_cnt_q + 16'd1;
         if (und_inc && (und_cnt_q != 16'hFFFF)) und_cnt_q <= und_cnt_q + 16'd1;
      end
   end

   assign stat_overflow_cnt = ovf_cnt_q;
   assign stat_underrun_cnt = und_cnt_q;
`else
   logic unused_stats;
   assign unused_stats      = ovf_inc | und_inc;
   assign stat_overflow_cnt = 16'h0000;
   assign stat_underrun_cnt = 16'h0000;
`endif
endmodule

// File: doc/spi_slave_axis.md
# spi_slave_axis

Single-clock SPI responder for the housekeeping path. It oversamples an external SPI bus (mode 0, CPOL=0/CPHA=0) in the clk_core domain and deserialises MOSI bytes onto an AXI-Stream master, marking the last byte of each chip-select frame with tlast. It serialises bytes from an AXI-Stream slave onto MISO. It is the counterpart of the housekeeping SPI master and serves as an on-board ADC/DAC emulator and as a bench responder.

## Interface
Parameters:
- MSB_FIRST, 0: 0 shifts bit 0 first on both MOSI and MISO; 1 shifts bit 7 first.
- IDLE_BYTE, 8'hFF: MISO byte driven when no transmit data is held.
- SYNC_STAGES, 2: synchroniser depth for spi_clk, spi_csn and spi_mosi; minimum 2.

Ports:
- clk_core  in  1  sole clock.
- clk_core_resn  in  1  reset; asynchronous assert, active-low.
- spi_clk  in  1  external SPI clock, asynchronous to clk_core.
- spi_csn  in  1  chip select, active-low.
- spi_mosi  in  1  master-out data.
- spi_miso  out  1  slave-out data.
- spi_miso_oe  out  1  MISO output enable; high while selected.
- m_axis_tdata  out  8  received byte.
- m_axis_tvalid  out  1  received byte valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last complete byte of the frame.
- s_axis_tdata  in  8  byte to transmit.
- s_axis_tvalid  in  1  transmit byte valid.
- s_axis_tready  out  1  transmit holding register empty.
- busy  out  1  high in state SHIFT.
- stat_overflow_cnt  out  16  dropped receive bytes.
- stat_underrun_cnt  out  16  IDLE_BYTE slots shifted.

## Operation
- All three SPI inputs pass through SYNC_STAGES flops. An extra flop produces one-cycle strobes: sclk_rise, sclk_fall, csn_fall, csn_rise.
- State IDLE goes to SHIFT on csn_fall. SHIFT goes to IDLE on csn_rise. csn_rise has priority over a simultaneous clock strobe, and that clock strobe is ignored. spi_clk strobes are ignored in IDLE.
- Receive path:
  - On sclk_rise, the MOSI bit shifts into rx_shift and bit_cnt increments (0..7, wraps).
  - When the 8th bit lands, the byte moves to the pending register.
  - If pending was already full, its old byte is first pushed to the output register with tlast=0.
  - On csn_rise with pending full, pending is pushed with tlast=1.
  - A partial byte (bit_cnt≠0) at csn_rise is discarded and bit_cnt clears.
- Push rule:
  - If the output register is empty, or is being consumed (tvalid&tready) in the same cycle, the pushed byte is accepted.
  - Otherwise the pushed byte is dropped and the overflow count increments. The output register keeps its contents.
- Transmit path:
  - s_axis loads a one-byte holding register; s_axis_tready equals "holding empty".
  - A byte slot starts on csn_fall, and on the sclk_fall that follows the 8th sclk_rise of a slot.
  - At slot start, tx_shift loads from the holding register (which is then cleared) or, if holding is empty, loads IDLE_BYTE and flags the slot idle.
  - Each subsequent sclk_fall within the slot advances to the next bit.
  - The underrun count increments on the first sclk_rise of an idle-flagged slot. A slot that ends by csn_rise before any sclk_rise is not counted, and its loaded data byte is lost.
- spi_miso outputs the current tx_shift bit while in SHIFT, and 0 in IDLE. spi_miso_oe is 1 in SHIFT.
- Both counters saturate at 16'hFFFF and clear only on reset.

## Timing
- Reset values: spi_miso=0, spi_miso_oe=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, s_axis_tready=1, busy=0, both counters=0. The state returns to IDLE and all registers clear, including on reset mid-frame.
- Pin edge to strobe: SYNC_STAGES+1 clk_core cycles, ±1 cycle of sampling uncertainty.
- Pin edge to spi_miso update: SYNC_STAGES+2 cycles (registered output).
- Bus constraints: the spi_clk high and low phases, and the gap from CSn fall to the first spi_clk rise, are each at least SYNC_STAGES+4 clk_core cycles. With SYNC_STAGES=2, clk_core must be ≥12× spi_clk.
- m_axis_tvalid rises the cycle after a push and holds until the tready handshake. tdata and tlast are stable while tvalid is high.
- Last byte of a frame: m_axis_tvalid rises 1 cycle after csn_rise.

## Configuration
- SPI_SLAVE_STATS_EN defined: the overflow and underrun counters are built as described.
- SPI_SLAVE_STATS_EN undefined: counter logic is omitted; both stat ports are tied to 16'h0000. The drop and IDLE_BYTE behaviour is unchanged.

## Test plan
- Reset: hold resn low mid-frame, then release -> every output at its reset value; the next frame is received correctly.
- Receive: frame of 0x5A, 0x01, 0xC3 (MSB_FIRST=0), tready=1 -> three beats; tlast=1 only on 0xC3.
- Transmit: preload 0xA5, then 0x3C fed when tready allows; 3-byte frame -> MISO carries 0xA5, 0x3C, 0xFF; stat_underrun_cnt=1.
- Overflow: tready=0 during a 3-byte frame 0x11, 0x22, 0x33, then tready=1 -> single beat 0x11 with tlast=0; stat_overflow_cnt=2.
- Partial byte: 0x77 followed by 5 bits, then CSn rises -> one beat 0x77 with tlast=1; the partial byte never appears.
- Undefined SPI_SLAVE_STATS_EN: repeat the overflow test -> same data beats; stat_overflow_cnt=0.
